// File: rtl/ifu_inst_queue_if.sv
// Fetch-side and decoder-side signals of the instruction queue.
// IQ_PC_TRACK_EN adds the packet PC input and the per-slot PC outputs.
interface ifu_inst_queue_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             icache_valid;
    logic [3:0][31:0] icache_instr;
    logic [3:0]       icache_mask;
    logic             iq_ready;
    logic [31:0]      instr_0;
    logic [31:0]      instr_1;
    logic [31:0]      instr_2;
    logic [31:0]      instr_3;
    logic [3:0]       fetch_valid;
    logic             ifu_valid;
    logic             decoder_ready;
    logic [CNT_W-1:0] iq_count;
`ifdef IQ_PC_TRACK_EN
    logic [31:0]      icache_pc;
    logic [31:0]      pc_0;
    logic [31:0]      pc_1;
    logic [31:0]      pc_2;
    logic [31:0]      pc_3;

    modport master (
        output flush, icache_valid, icache_instr, icache_mask, decoder_ready, icache_pc,
        input  iq_ready, instr_0, instr_1, instr_2, instr_3, fetch_valid, ifu_valid, iq_count,
        input  pc_0, pc_1, pc_2, pc_3
    );
    modport slave (
        input  flush, icache_valid, icache_instr, icache_mask, decoder_ready, icache_pc,
        output iq_ready, instr_0, instr_1, instr_2, instr_3, fetch_valid, ifu_valid, iq_count,
        output pc_0, pc_1, pc_2, pc_3
    );
`else
    modport master (
        output flush, icache_valid, icache_instr, icache_mask, decoder_ready,
        input  iq_ready, instr_0, instr_1, instr_2, instr_3, fetch_valid, ifu_valid, iq_count
    );
    modport slave (
        input  flush, icache_valid, icache_instr, icache_mask, decoder_ready,
        output iq_ready, instr_0, instr_1, instr_2, instr_3, fetch_valid, ifu_valid, iq_count
    );
`endif
endinterface

// File: rtl/ifu_inst_queue.sv
// Compacting instruction fetch queue between the I-cache and decode.
// IQ_PC_TRACK_EN stores a per-instruction PC alongside each entry.
module ifu_inst_queue #(
    parameter int unsigned DEPTH = 16
) (
    input logic            clk,
    input logic            rst_n,
    ifu_inst_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             iq_ready, ifu_valid, enq, deq;
    logic [2:0]       n_enq, n_deq;
    logic [3:0][2:0]  slot_off;
    logic [3:0]       fetch_valid;
    logic [3:0][31:0] instr_out;

    // Readiness uses the registered count so a same-cycle dequeue cannot open space.
    assign iq_ready  = count_q <= CNT_W'(DEPTH - 4);
    assign ifu_valid = count_q != '0;
    assign enq       = bus.icache_valid && iq_ready && !bus.flush;
    assign deq       = ifu_valid && bus.decoder_ready && !bus.flush;
    assign n_deq     = (count_q >= CNT_W'(4)) ? 3'd4 : count_q[2:0];

    // Each set slot lands at tail plus the number of set slots below it.
    always_comb begin
        n_enq    = '0;
        slot_off = '0;
        for (int i = 0; i < 4; i++) begin
            slot_off[i] = n_enq;
            if (bus.icache_mask[i]) n_enq = n_enq + 3'd1;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(n_enq);
            if (deq) head_d = head_q + PTR_W'(n_deq);
            count_d = count_q + CNT_W'(enq ? n_enq : 3'd0) - CNT_W'(deq ? n_deq : 3'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.icache_mask[i]) mem_q[tail_q + PTR_W'(slot_off[i])] <= bus.icache_instr[i];
            end
        end
    end

    always_comb begin
        fetch_valid = '0;
        instr_out   = '0;
        for (int i = 0; i < 4; i++) begin
            fetch_valid[i] = count_q > CNT_W'(i);
            if (fetch_valid[i]) instr_out[i] = mem_q[head_q + PTR_W'(i)];
        end
    end

    assign bus.iq_ready    = iq_ready;
    assign bus.ifu_valid   = ifu_valid;
    assign bus.fetch_valid = fetch_valid;
    assign bus.iq_count    = count_q;
    assign bus.instr_0     = instr_out[0];
    assign bus.instr_1     = instr_out[1];
    assign bus.instr_2     = instr_out[2];
    assign bus.instr_3     = instr_out[3];

`ifdef IQ_PC_TRACK_EN
    logic [31:0]      pc_mem_q [DEPTH];
    logic [3:0][31:0] pc_out;

    // PC reflects the original slot position, not the compacted one.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.icache_mask[i]) begin
                    pc_mem_q[tail_q + PTR_W'(slot_off[i])] <= bus.icache_pc + 32'(i) * 32'd4;
                end
            end
        end
    end

    always_comb begin
        pc_out = '0;
        for (int i = 0; i < 4; i++) begin
            if (fetch_valid[i]) pc_out[i] = pc_mem_q[head_q + PTR_W'(i)];
        end
    end

    assign bus.pc_0 = pc_out[0];
    assign bus.pc_1 = pc_out[1];
    assign bus.pc_2 = pc_out[2];
    assign bus.pc_3 = pc_out[3];
`endif
endmodule

// File: tb/tb_ifu_inst_queue.sv
// Randomized bench for ifu_inst_queue against a queue-based reference model.
// Honours IQ_PC_TRACK_EN for the PC outputs.
module tb_ifu_inst_queue;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_inst_queue_if #(.DEPTH(DEPTH)) bus ();
    ifu_inst_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] mq[$];
    logic [31:0] pq[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int sz;
        logic [31:0] ins[4];
        logic fv;
        sz = mq.size();
        ins = '{bus.instr_0, bus.instr_1, bus.instr_2, bus.instr_3};
        check_eq("iq_count", 32'(bus.iq_count), 32'(sz));
        check_eq("iq_ready", 32'(bus.iq_ready), 32'(int'(DEPTH) - sz >= 4));
        check_eq("ifu_valid", 32'(bus.ifu_valid), 32'(sz != 0));
        for (int i = 0; i < 4; i++) begin
            fv = sz > i;
            check_eq($sformatf("fetch_valid[%0d]", i), 32'(bus.fetch_valid[i]), 32'(fv));
            check_eq($sformatf("instr_%0d", i), ins[i], fv ? mq[i] : 32'h0);
        end
`ifdef IQ_PC_TRACK_EN
        begin
            logic [31:0] pcs[4];
            pcs = '{bus.pc_0, bus.pc_1, bus.pc_2, bus.pc_3};
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("pc_%0d", i), pcs[i], (sz > i) ? pq[i] : 32'h0);
        end
`endif
    endtask

    // Called at a falling edge: apply inputs, advance the model, check after the next edge.
    task automatic step(input logic v, input logic [3:0] mask, input logic [3:0][31:0] ins,
                        input logic [31:0] pc, input logic dr, input logic fl);
        int sz;
        bit rdy;
        bus.icache_valid  = v;
        bus.icache_mask   = mask;
        bus.icache_instr  = ins;
        bus.decoder_ready = dr;
        bus.flush         = fl;
`ifdef IQ_PC_TRACK_EN
        bus.icache_pc     = pc;
`endif
        sz  = mq.size();
        rdy = (int'(DEPTH) - sz) >= 4;
        if (fl) begin
            mq.delete();
            pq.delete();
        end else begin
            if (sz > 0 && dr) begin
                for (int k = 0; k < ((sz < 4) ? sz : 4); k++) begin
                    void'(mq.pop_front());
                    void'(pq.pop_front());
                end
            end
            if (v && rdy) begin
                for (int i = 0; i < 4; i++) begin
                    if (mask[i]) begin
                        mq.push_back(ins[i]);
                        pq.push_back(pc + 32'(4 * i));
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [3:0][31:0] pkt(input logic [31:0] base);
        logic [3:0][31:0] p;
        for (int i = 0; i < 4; i++) p[i] = base + 32'(i);
        return p;
    endfunction

    function automatic logic [3:0][31:0] rnd_pkt();
        logic [3:0][31:0] p;
        for (int i = 0; i < 4; i++) p[i] = $urandom;
        return p;
    endfunction

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        pq.delete();
        check_outputs();
        check_eq("rst_count", 32'(bus.iq_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        int vp, dp;
        bus.icache_valid  = 1'b0;
        bus.icache_mask   = '0;
        bus.icache_instr  = '0;
        bus.decoder_ready = 1'b0;
        bus.flush         = 1'b0;
`ifdef IQ_PC_TRACK_EN
        bus.icache_pc     = '0;
`endif
        repeat (2) @(negedge clk);
        check_outputs();
        check_eq("rst_ready", 32'(bus.iq_ready), 32'h1);
        check_eq("rst_fv", 32'(bus.fetch_valid), 32'h0);
        rst_n = 1'b1;

        // Full packet visible next cycle.
        step(1, 4'b1111, pkt(32'hA000_0000), 32'h0, 0, 0);
        check_eq("full_pkt_instr3", bus.instr_3, 32'hA000_0003);
        check_eq("full_pkt_count", 32'(bus.iq_count), 32'd4);
        step(0, 4'b0000, '0, 32'h0, 0, 1);

        // Compaction of mask 1010.
        step(1, 4'b1010, pkt(32'hB000_0000), 32'h1000, 0, 0);
        check_eq("compact_i0", bus.instr_0, 32'hB000_0001);
        check_eq("compact_i1", bus.instr_1, 32'hB000_0003);
        check_eq("compact_fv", 32'(bus.fetch_valid), 32'h3);
`ifdef IQ_PC_TRACK_EN
        check_eq("compact_pc0", bus.pc_0, 32'h1004);
        check_eq("compact_pc1", bus.pc_1, 32'h100C);
`endif
        step(0, 4'b0000, '0, 32'h0, 0, 1);

        // Fill to DEPTH, hold a fifth packet, then one dequeue.
        for (int p = 0; p < 4; p++) step(1, 4'b1111, pkt(32'hC000_0000 + 32'(p * 16)), 0, 0, 0);
        check_eq("full_count", 32'(bus.iq_count), 32'd16);
        check_eq("full_ready", 32'(bus.iq_ready), 32'h0);
        step(1, 4'b1111, pkt(32'hD000_0000), 0, 0, 0);
        check_eq("held_count", 32'(bus.iq_count), 32'd16);
        step(1, 4'b1111, pkt(32'hD000_0000), 0, 1, 0);
        check_eq("deq_count", 32'(bus.iq_count), 32'd12);
        check_eq("deq_ready", 32'(bus.iq_ready), 32'h1);
        step(1, 4'b1111, pkt(32'hD000_0000), 0, 0, 0);
        check_eq("accept_count", 32'(bus.iq_count), 32'd16);

        // Flush with enqueue and dequeue pending (count 16 >= 9).
        step(0, 4'b0000, '0, 0, 1, 0);
        step(0, 4'b0000, '0, 0, 0, 0);
        check_eq("pre_flush_count", 32'(bus.iq_count), 32'd12);
        step(0, 4'b0000, '0, 0, 1, 0);
        step(1, 4'b1000, pkt(32'hD100_0000), 0, 0, 0);
        check_eq("nine_count", 32'(bus.iq_count), 32'd9);
        step(1, 4'b1111, pkt(32'hE000_0000), 0, 1, 1);
        check_eq("flush_count", 32'(bus.iq_count), 32'd0);
        check_eq("flush_i0", bus.instr_0, 32'h0);

        // Simultaneous enqueue and dequeue at count 6.
        step(1, 4'b1111, pkt(32'hF000_0000), 0, 0, 0);
        step(1, 4'b0011, pkt(32'hF000_0004), 0, 0, 0);
        step(1, 4'b0111, pkt(32'hF100_0000), 0, 1, 0);
        check_eq("simul_count", 32'(bus.iq_count), 32'd5);
        check_eq("simul_i0", bus.instr_0, 32'hF000_0004);
        step(0, 4'b0000, '0, 0, 0, 1);

        // Drive head and tail to 14, then wrap a full packet.
        for (int p = 0; p < 3; p++) step(1, 4'b1111, pkt(32'h1000_0000 + 32'(p * 16)), 0, 0, 0);
        step(1, 4'b0011, pkt(32'h1000_0030), 0, 0, 0);
        for (int p = 0; p < 4; p++) step(0, 4'b0000, '0, 0, 1, 0);
        check_eq("wrap_empty", 32'(bus.iq_count), 32'd0);
        step(1, 4'b1111, pkt(32'h2000_0000), 0, 0, 0);
        check_eq("wrap_i0", bus.instr_0, 32'h2000_0000);
        check_eq("wrap_i3", bus.instr_3, 32'h2000_0003);
        step(1, 4'b0101, pkt(32'h2100_0000), 0, 1, 0);
        check_eq("wrap_after_i0", bus.instr_0, 32'h2100_0000);

        // Random traffic with shifting fill/drain bias.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 300) % 4)
                0: begin vp = 90; dp = 15; end
                1: begin vp = 30; dp = 90; end
                2: begin vp = 70; dp = 60; end
                default: begin vp = 95; dp = 40; end
            endcase
            step(($urandom_range(99) < vp), 4'($urandom), rnd_pkt(), $urandom,
                 ($urandom_range(99) < dp), ($urandom_range(199) < 3));
            if (c == 1317) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
